// File: rtl/ex_pkg.sv
// Shared definitions for the multi-channel MCU SPI expansion push block:
// register map, STATUS bit positions, receiver FSM states and the
// channel-index width helper.
package ex_pkg;

    // Register offsets within the module window (addr[7:0])
    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h01;
    localparam logic [7:0] REG_FCNT_L = 8'h02;
    localparam logic [7:0] REG_FCNT_H = 8'h03;
    localparam logic [7:0] REG_SEL    = 8'h04;

    // CTRL bit positions
    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    // STATUS bit positions
    localparam int ST_FRAME   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_SHORT   = 2;

    // Per-channel receiver states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } rx_state_t;

    // Channel-index width: at least one bit even for a single channel
    function automatic int calc_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ex_spi_rx.sv
// One MCU SPI slave receive channel: synchronises csn/sck/mosi into the
// system clock, assembles MSB-first bytes into a frame buffer and reports
// the outcome of each chip-select frame with single-cycle pulses.
module ex_spi_rx
    import ex_pkg::*;
#(
    parameter int EXP_W = 256
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             csn,
    input  logic             sck,
    input  logic             mosi,
    output logic [EXP_W-1:0] frame_buf,
    output logic             frame_full,
    output logic             frame_done,
    output logic             short_err,
    output logic             overrun
);

    localparam int             NBYTES  = EXP_W / 8;
    localparam int             BCW     = $clog2(NBYTES + 1);
    localparam logic [BCW-1:0] BC_FULL = BCW'(NBYTES);

    logic csn_s1_reg, csn_s2_reg, csn_d_reg;
    logic sck_s1_reg, sck_s2_reg, sck_d_reg;
    logic mosi_s1_reg, mosi_s2_reg;
    logic csn_rise_reg, csn_fall_reg, sck_rise_reg, mosi_q_reg;

    rx_state_t      state_reg;
    logic [2:0]     bit_cnt_reg;
    logic [6:0]     shreg_reg;
    logic [BCW-1:0] byte_cnt_reg;

    // Two-stage synchronisers, a delayed copy, and registered edge events.
    // csn resets low so that a reset released in the middle of a transfer
    // (csn still low) never looks like a fresh falling edge; the rising
    // edge that appears when csn is idle-high after reset is ignored in IDLE.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            csn_s1_reg   <= 1'b0;
            csn_s2_reg   <= 1'b0;
            csn_d_reg    <= 1'b0;
            sck_s1_reg   <= 1'b0;
            sck_s2_reg   <= 1'b0;
            sck_d_reg    <= 1'b0;
            mosi_s1_reg  <= 1'b0;
            mosi_s2_reg  <= 1'b0;
            csn_rise_reg <= 1'b0;
            csn_fall_reg <= 1'b0;
            sck_rise_reg <= 1'b0;
            mosi_q_reg   <= 1'b0;
        end else begin
            csn_s1_reg   <= csn;
            csn_s2_reg   <= csn_s1_reg;
            csn_d_reg    <= csn_s2_reg;
            sck_s1_reg   <= sck;
            sck_s2_reg   <= sck_s1_reg;
            sck_d_reg    <= sck_s2_reg;
            mosi_s1_reg  <= mosi;
            mosi_s2_reg  <= mosi_s1_reg;
            csn_rise_reg <= csn_s2_reg & ~csn_d_reg;
            csn_fall_reg <= ~csn_s2_reg & csn_d_reg;
            sck_rise_reg <= sck_s2_reg & ~sck_d_reg;
            // mosi travels the same depth as sck, so it stays aligned to the edge
            mosi_q_reg   <= mosi_s2_reg;
        end
    end

    // Frame FSM: collect bits while selected, evaluate the byte count in CHECK
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            shreg_reg    <= 7'd0;
            byte_cnt_reg <= '0;
            frame_buf    <= '0;
            frame_done   <= 1'b0;
            short_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            short_err  <= 1'b0;
            overrun    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (csn_fall_reg) begin
                        state_reg    <= RECV;
                        bit_cnt_reg  <= 3'd0;
                        byte_cnt_reg <= '0;
                        frame_buf    <= '0;
                    end
                end
                RECV: begin
                    if (csn_rise_reg) begin
                        // Any partial byte still in the shifter is dropped here
                        state_reg  <= CHECK;
                        frame_done <= 1'b1;
                        short_err  <= (byte_cnt_reg != '0) && (byte_cnt_reg != BC_FULL);
                    end else if (sck_rise_reg) begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        shreg_reg   <= {shreg_reg[5:0], mosi_q_reg};
                        if (bit_cnt_reg == 3'd7) begin
                            if (byte_cnt_reg == BC_FULL) begin
                                overrun <= 1'b1;
                            end else begin
                                frame_buf    <= {frame_buf[EXP_W-9:0], shreg_reg, mosi_q_reg};
                                byte_cnt_reg <= byte_cnt_reg + BCW'(1);
                            end
                        end
                    end
                end
                CHECK: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A completed frame holds exactly the buffer's worth of bytes
    assign frame_full = (byte_cnt_reg == BC_FULL);

endmodule

// File: rtl/ex_push_mc.sv
// Multi-channel MCU SPI expansion push: NCH receive channels, a commit
// mux that lets only the selected channel update exp_data, and the fx-bus
// register slave (enable, sticky status, frame counter, select readback).
module ex_push_mc
    import ex_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int EXP_W = 256,
    parameter int CW    = calc_cw(NCH)
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic [NCH-1:0]   mcu_csn,
    input  logic [NCH-1:0]   mcu_sck,
    input  logic [NCH-1:0]   mcu_mosi,
    input  logic [CW-1:0]    mcu_sel,
    output logic [EXP_W-1:0] exp_data,
    output logic             exp_vld,
    input  logic             fx_wr,
    input  logic [15:0]      fx_waddr,
    input  logic [7:0]       fx_data,
    input  logic             fx_rd,
    input  logic [15:0]      fx_raddr,
    output logic [7:0]       fx_q,
    input  logic [5:0]       mod_id
);

    logic [EXP_W-1:0] ch_buf [NCH];
    logic [NCH-1:0]   ch_full;
    logic [NCH-1:0]   ch_done;
    logic [NCH-1:0]   ch_short;
    logic [NCH-1:0]   ch_ovr;

    logic             en_reg;
    logic [2:0]       status_reg;
    logic [2:0]       status_next;
    logic [15:0]      fcnt_reg;
    logic [15:0]      fcnt_next;

    logic             commit;
    logic [EXP_W-1:0] commit_data;

    logic             wr_hit, rd_hit;
    logic             ctrl_wr, status_wr, fcnt_l_wr, fcnt_h_wr, clr_wr;
    logic [7:0]       rd_mux;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            ex_spi_rx #(
                .EXP_W (EXP_W)
            ) u_rx (
                .clk_sys    (clk_sys),
                .rst        (rst),
                .csn        (mcu_csn[gi]),
                .sck        (mcu_sck[gi]),
                .mosi       (mcu_mosi[gi]),
                .frame_buf  (ch_buf[gi]),
                .frame_full (ch_full[gi]),
                .frame_done (ch_done[gi]),
                .short_err  (ch_short[gi]),
                .overrun    (ch_ovr[gi])
            );
        end
    endgenerate

    // Commit mux: only the selected channel's full frame, and only when enabled.
    // mcu_sel is looked at only while that channel sits in CHECK.
    always_comb begin
        commit      = 1'b0;
        commit_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if ((mcu_sel == CW'(i)) && ch_done[i] && ch_full[i]) begin
                commit      = en_reg;
                commit_data = ch_buf[i];
            end
        end
    end

    // Output register: exp_data holds the last committed frame
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            exp_data <= '0;
            exp_vld  <= 1'b0;
        end else begin
            exp_vld <= commit;
            if (commit) begin
                exp_data <= commit_data;
            end
        end
    end

    // Bus address decode: module id in [15:10], [9:8] must be zero
    always_comb begin
        wr_hit    = fx_wr && (fx_waddr[15:10] == mod_id) && (fx_waddr[9:8] == 2'b00);
        rd_hit    = fx_rd && (fx_raddr[15:10] == mod_id) && (fx_raddr[9:8] == 2'b00);
        ctrl_wr   = wr_hit && (fx_waddr[7:0] == REG_CTRL);
        status_wr = wr_hit && (fx_waddr[7:0] == REG_STATUS);
        fcnt_l_wr = wr_hit && (fx_waddr[7:0] == REG_FCNT_L);
        fcnt_h_wr = wr_hit && (fx_waddr[7:0] == REG_FCNT_H);
        clr_wr    = ctrl_wr && fx_data[CTRL_CLR];
    end

    // Next-state for sticky status and frame counter: set beats clear,
    // CLR beats a same-cycle increment or preset
    always_comb begin
        status_next = status_reg & ~(status_wr ? fx_data[2:0] : 3'b000);
        status_next[ST_FRAME]   = status_next[ST_FRAME]   | commit;
        status_next[ST_OVERRUN] = status_next[ST_OVERRUN] | (|ch_ovr);
        status_next[ST_SHORT]   = status_next[ST_SHORT]   | (|ch_short);

        fcnt_next = fcnt_reg + {15'd0, commit};
        if (fcnt_l_wr) begin
            fcnt_next[7:0] = fx_data;
        end
        if (fcnt_h_wr) begin
            fcnt_next[15:8] = fx_data;
        end
        if (clr_wr) begin
            fcnt_next = 16'd0;
        end
    end

    // Register file state
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            en_reg     <= 1'b1;
            status_reg <= 3'b000;
            fcnt_reg   <= 16'd0;
        end else begin
            if (ctrl_wr) begin
                en_reg <= fx_data[CTRL_EN];
            end
            status_reg <= status_next;
            fcnt_reg   <= fcnt_next;
        end
    end

    // Read data selection; CLR is self-clearing so it always reads 0
    always_comb begin
        case (fx_raddr[7:0])
            REG_CTRL:   rd_mux = {7'd0, en_reg};
            REG_STATUS: rd_mux = {5'd0, status_reg};
            REG_FCNT_L: rd_mux = fcnt_reg[7:0];
            REG_FCNT_H: rd_mux = fcnt_reg[15:8];
            REG_SEL:    rd_mux = 8'(mcu_sel);
            default:    rd_mux = 8'h00;
        endcase
    end

    // Registered read port: zero unless this cycle's read hit the module
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            fx_q <= 8'h00;
        end else begin
            fx_q <= rd_hit ? rd_mux : 8'h00;
        end
    end

endmodule

// File: tb/tb_ex_push_mc.sv
// Self-checking bench for ex_push_mc (NCH=2, EXP_W=256).
module tb_ex_push_mc;

    localparam int         NCH   = 2;
    localparam int         EXP_W = 256;
    localparam int         NB    = EXP_W / 8;
    localparam int         CW    = 1;
    localparam logic [5:0] MID   = 6'h05;

    logic             clk_sys = 1'b0;
    logic             rst     = 1'b1;
    logic [NCH-1:0]   mcu_csn = '1;
    logic [NCH-1:0]   mcu_sck = '0;
    logic [NCH-1:0]   mcu_mosi = '0;
    logic [CW-1:0]    mcu_sel = '0;
    logic [EXP_W-1:0] exp_data;
    logic             exp_vld;
    logic             fx_wr = 1'b0;
    logic [15:0]      fx_waddr = 16'h0;
    logic [7:0]       fx_data = 8'h0;
    logic             fx_rd = 1'b0;
    logic [15:0]      fx_raddr = 16'h0;
    logic [7:0]       fx_q;
    logic [5:0]       mod_id = MID;

    ex_push_mc #(
        .NCH   (NCH),
        .EXP_W (EXP_W)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .mcu_csn  (mcu_csn),
        .mcu_sck  (mcu_sck),
        .mcu_mosi (mcu_mosi),
        .mcu_sel  (mcu_sel),
        .exp_data (exp_data),
        .exp_vld  (exp_vld),
        .fx_wr    (fx_wr),
        .fx_waddr (fx_waddr),
        .fx_data  (fx_data),
        .fx_rd    (fx_rd),
        .fx_raddr (fx_raddr),
        .fx_q     (fx_q),
        .mod_id   (mod_id)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state owned by the stimulus process
    bit               m_en = 1'b1;
    logic [2:0]       m_status = 3'b000;
    logic [15:0]      m_fcnt = 16'h0;
    int               m_sel = 0;
    logic [EXP_W-1:0] m_pend = '0;
    int               m_due = -1;
    // Pending read / literal data expectations
    int               q_chk_cyc = -1;
    logic [7:0]       q_exp = 8'h00;
    string            q_name = "";
    int               d_chk_cyc = -1;
    logic [EXP_W-1:0] d_lit = '0;

    // Compare process: every cycle, strobe, held frame and read port
    initial begin : compare
        logic [EXP_W-1:0] c_data;
        logic             want_vld;
        logic [7:0]       want_q;
        c_data = '0;
        forever begin
            @(negedge clk_sys);
            if (rst) c_data = '0;
            want_vld = 1'b0;
            if (m_due >= 0 && cyc == m_due) begin
                want_vld = 1'b1;
                c_data   = m_pend;
            end
            checks++;
            if (exp_vld !== want_vld) begin
                errors++;
                $display("FAIL exp_vld cyc=%0d got %b want %b", cyc, exp_vld, want_vld);
            end
            checks++;
            if (exp_data !== c_data) begin
                errors++;
                $display("FAIL exp_data cyc=%0d got %h want %h", cyc, exp_data, c_data);
            end
            want_q = (cyc == q_chk_cyc) ? q_exp : 8'h00;
            checks++;
            if (fx_q !== want_q) begin
                errors++;
                $display("FAIL fx_q[%s] cyc=%0d got %02h want %02h",
                         (cyc == q_chk_cyc) ? q_name : "idle", cyc, fx_q, want_q);
            end
            if (cyc == d_chk_cyc) begin
                checks++;
                if (exp_data !== d_lit) begin
                    errors++;
                    $display("FAIL exp_data_lit cyc=%0d got %h want %h", cyc, exp_data, d_lit);
                end
            end
        end
    end

    function automatic logic [15:0] reg_addr(input logic [5:0] id, input logic [7:0] ofs);
        return {id, 2'b00, ofs};
    endfunction

    // Register write semantics applied to the model
    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        if (a[15:10] == MID && a[9:8] == 2'b00) begin
            case (a[7:0])
                8'h00: begin
                    m_en = d[0];
                    if (d[1]) m_fcnt = 16'h0;
                end
                8'h01: m_status = m_status & ~d[2:0];
                8'h02: m_fcnt[7:0] = d;
                8'h03: m_fcnt[15:8] = d;
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_en = 1'b1;
        m_status = 3'b000;
        m_fcnt = 16'h0;
        m_due = -1;
    endtask

    // Outcome of one chip-select frame, from the byte count alone
    task automatic model_frame(input int ch, input int nbits, input int base);
        int nbytes;
        logic [EXP_W-1:0] d;
        nbytes = nbits / 8;
        if (nbytes > NB) m_status[1] = 1'b1;
        if (nbytes > 0 && nbytes < NB) m_status[2] = 1'b1;
        if (nbytes >= NB && ch == m_sel && m_en) begin
            d = '0;
            for (int j = 0; j < NB; j++) d = {d[EXP_W-9:0], 8'(base + j)};
            m_pend = d;
            m_due = cyc + 5;
            m_status[0] = 1'b1;
            m_fcnt = m_fcnt + 16'd1;
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk_sys);
        fx_wr = 1'b1;
        fx_waddr = a;
        fx_data = d;
        model_write(a, d);
        @(negedge clk_sys);
        fx_wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [15:0] a, input logic [7:0] e, input string nm);
        @(negedge clk_sys);
        fx_rd = 1'b1;
        fx_raddr = a;
        q_exp = e;
        q_name = nm;
        q_chk_cyc = cyc + 1;
        @(negedge clk_sys);
        fx_rd = 1'b0;
    endtask

    task automatic set_sel(input int s);
        @(negedge clk_sys);
        mcu_sel = CW'(s);
        m_sel = s;
    endtask

    // Drive both channels in lockstep; a channel with 0 bits stays deselected.
    // Byte j of channel c is base_c + j. rst_bit >= 0 pulses reset at that bit.
    task automatic xfer(input int nb0, input int nb1, input int base0, input int base1,
                        input int rst_bit);
        int nbits[NCH];
        int base[NCH];
        int tmax;
        bit aborted;
        logic [7:0] bv;
        nbits[0] = nb0; nbits[1] = nb1;
        base[0] = base0; base[1] = base1;
        tmax = (nb0 > nb1) ? nb0 : nb1;
        aborted = 1'b0;
        @(negedge clk_sys);
        for (int c = 0; c < NCH; c++) if (nbits[c] > 0) mcu_csn[c] = 1'b0;
        repeat (4) @(negedge clk_sys);
        for (int t = 0; t < tmax; t++) begin
            if (t == rst_bit) begin
                #1 rst = 1'b1;
                model_reset();
                repeat (3) @(negedge clk_sys);
                rst = 1'b0;
                aborted = 1'b1;
            end
            for (int c = 0; c < NCH; c++) begin
                if (t < nbits[c]) begin
                    bv = 8'(base[c] + t / 8);
                    mcu_mosi[c] = bv[7 - (t % 8)];
                end
            end
            repeat (4) @(negedge clk_sys);
            for (int c = 0; c < NCH; c++) if (t < nbits[c]) mcu_sck[c] = 1'b1;
            repeat (4) @(negedge clk_sys);
            mcu_sck = '0;
        end
        repeat (4) @(negedge clk_sys);
        mcu_csn = '1;
        if (!aborted) begin
            for (int c = 0; c < NCH; c++) if (nbits[c] > 0) model_frame(c, nbits[c], base[c]);
        end
        mcu_mosi = '0;
        repeat (12) @(negedge clk_sys);
    endtask

    initial begin : stim
        repeat (4) @(negedge clk_sys);
        rst = 1'b0;

        // Reset state
        rd_chk(reg_addr(MID, 8'h00), 8'h01, "ctrl_rst");
        rd_chk(reg_addr(MID, 8'h01), 8'h00, "status_rst");
        rd_chk(reg_addr(MID, 8'h02), 8'h00, "fcnt_l_rst");
        rd_chk(reg_addr(MID, 8'h04), 8'h00, "sel_rst");

        // Full frame on ch0, selected
        set_sel(0);
        xfer(NB * 8, 0, 8'h00, 0, -1);
        d_lit = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        d_chk_cyc = m_due + 1;
        rd_chk(reg_addr(MID, 8'h01), 8'h01, "status_frame");
        rd_chk(reg_addr(MID, 8'h02), 8'h01, "fcnt_l_one");
        rd_chk(reg_addr(MID, 8'h03), 8'h00, "fcnt_h_one");

        // Full frame on a non-selected channel
        set_sel(1);
        xfer(NB * 8, 0, 8'h20, 0, -1);
        rd_chk(reg_addr(MID, 8'h01), {5'd0, m_status}, "status_nosel");
        rd_chk(reg_addr(MID, 8'h04), 8'h01, "sel_one");

        // 33 bytes: first 32 commit, overrun flagged, then W1C of overrun
        set_sel(0);
        xfer((NB + 1) * 8, 0, 8'h40, 0, -1);
        rd_chk(reg_addr(MID, 8'h01), 8'h03, "status_ovr");
        wr(reg_addr(MID, 8'h01), 8'h02);
        rd_chk(reg_addr(MID, 8'h01), 8'h01, "status_w1c");

        // 5 bytes + 3 bits: short, no commit
        xfer(43, 0, 8'h60, 0, -1);
        rd_chk(reg_addr(MID, 8'h01), 8'h05, "status_short");

        // Both channels concurrently, ch1 selected
        set_sel(1);
        xfer(NB * 8, NB * 8, 8'h70, 8'h90, -1);
        rd_chk(reg_addr(MID, 8'h02), m_fcnt[7:0], "fcnt_l_dual");

        // Disabled: no commit
        set_sel(0);
        wr(reg_addr(MID, 8'h00), 8'h00);
        rd_chk(reg_addr(MID, 8'h00), 8'h00, "ctrl_dis");
        xfer(NB * 8, 0, 8'hB0, 0, -1);
        rd_chk(reg_addr(MID, 8'h02), m_fcnt[7:0], "fcnt_l_dis");
        wr(reg_addr(MID, 8'h00), 8'h01);

        // Counter wrap and clear
        wr(reg_addr(MID, 8'h02), 8'hFF);
        wr(reg_addr(MID, 8'h03), 8'hFF);
        rd_chk(reg_addr(MID, 8'h03), 8'hFF, "fcnt_h_preset");
        xfer(NB * 8, 0, 8'hC0, 0, -1);
        rd_chk(reg_addr(MID, 8'h02), 8'h00, "fcnt_l_wrap");
        rd_chk(reg_addr(MID, 8'h03), 8'h00, "fcnt_h_wrap");
        xfer(NB * 8, 0, 8'hD0, 0, -1);
        rd_chk(reg_addr(MID, 8'h02), 8'h01, "fcnt_l_after");
        wr(reg_addr(MID, 8'h00), 8'h03);
        rd_chk(reg_addr(MID, 8'h02), 8'h00, "fcnt_l_clr");
        rd_chk(reg_addr(MID, 8'h00), 8'h01, "ctrl_clr_rd");

        // Reset mid-frame at byte 10, then a clean frame
        xfer(NB * 8, 0, 8'hE0, 0, 80);
        rd_chk(reg_addr(MID, 8'h01), 8'h00, "status_abort");
        rd_chk(reg_addr(MID, 8'h02), 8'h00, "fcnt_l_abort");
        xfer(NB * 8, 0, 8'h11, 0, -1);
        rd_chk(reg_addr(MID, 8'h02), 8'h01, "fcnt_l_post");
        rd_chk(reg_addr(MID, 8'h01), 8'h01, "status_post");

        // Address decode misses
        rd_chk(reg_addr(6'h06, 8'h00), 8'h00, "miss_modid");
        rd_chk({MID, 2'b01, 8'h00}, 8'h00, "miss_hibits");
        rd_chk(reg_addr(MID, 8'h10), 8'h00, "unmapped");
        wr(reg_addr(6'h06, 8'h00), 8'h00);
        rd_chk(reg_addr(MID, 8'h00), 8'h01, "ctrl_after_miss_wr");

        repeat (4) @(negedge clk_sys);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
